data_bus_ctrl: RTL and testbench
================================

# data_bus_ctrl

Memory-mapped data-side bus controller that consumes the core's load/store port (address, write enable, store data) and returns load data to it. Decodes each access to a word-addressed on-chip data RAM or a small register bank: GPIO output, synchronised GPIO input, free-running cycle counter, timer compare and status. Sits directly downstream of the core's memory stage and is instantiated beside the core in the SoC top.

## Interface
Parameters:
- RAM_AW, 10, RAM word-address width (RAM depth = 2^RAM_AW words)
- GPIO_W, 32, GPIO width (≤ 32; unused upper read bits are 0)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset; asynchronous and active-high
- req_i  in  1  access qualifier; high only in the core's memory-stage cycle
- addr_i  in  32  byte address; addr_i[1:0] ignored (word accesses only)
- we_i  in  1  1 = store, 0 = load; meaningful only when req_i = 1
- wdata_i  in  32  store data
- rdata_o  out  32  registered load data
- gpio_in_i  in  GPIO_W  asynchronous external inputs
- gpio_out_o  out  GPIO_W  GPIO output register
- timer_irq_o  out  1  level: cycle count ≥ compare value, compare ≠ 0
- bus_err_o  out  1  sticky unmapped-access flag

## Operation
- Address map (word aligned):
  - 0x0000_0000 + 4·i, i < 2^RAM_AW: data RAM, R/W.
  - 0x1000_0000 GPIO_OUT: R/W.
  - 0x1000_0004 GPIO_IN: R/O; returns the 2-flop synchronised inputs.
  - 0x1000_0008 CYCLE: R/O count; any write clears it to 0.
  - 0x1000_000C TCMP: R/W.
  - 0x1000_0010 STATUS: bit0 = bus_err, bit1 = timer_irq; writing bit0 = 1 clears bus_err.
- Any other address is unmapped:
  - load returns 0;
  - store is ignored;
  - bus_err_o sets and holds until cleared via STATUS or reset.
- req_i = 0: no RAM or register write. rdata_o holds its last value.
- CYCLE increments every cycle and wraps from 0xFFFF_FFFF to 0.
- Store-to-CYCLE in the same cycle as an increment: clear wins, CYCLE = 0 next cycle.
- Simultaneous unmapped access and STATUS clear cannot occur (one access per cycle).
- timer_irq_o is combinational from the registered CYCLE and TCMP values.

## Timing
- Load latency: 1 cycle.
  - Address presented with req_i = 1, we_i = 0 in cycle N; rdata_o valid from cycle N+1 and held until the next load.
  - This matches the core's memory-stage → write-back ordering.
- Store: the target is updated at the rising edge ending cycle N. A load of the same address in N+1 returns the new value (N+2 on rdata_o).
- GPIO_IN latency: an external change is visible to a load issued 2 cycles later.
- bus_err_o rises the cycle after the offending access.
- Reset values:
  - rdata_o = 0, gpio_out_o = 0, CYCLE = 0, TCMP = 0;
  - timer_irq_o = 0, bus_err_o = 0, synchroniser flops = 0.
- RAM contents are not reset.
- Reset asserted mid-access aborts it; no write occurs in a cycle where rst = 1.

## Structure
- Address-map constants go in the shared defines file: base addresses, register offsets, STATUS bit positions.
- One sub-module, dmem_ram:
  - single-port synchronous RAM, 2^RAM_AW × 32;
  - write-enable and registered read;
  - no reset on the array.
- The top-level decode, register bank, counter and output mux live in data_bus_ctrl.

## Test plan
- Reset then RAM: store 0xDEADBEEF to 0x0000_0010, then load 0x0000_0010. rdata_o = 0xDEADBEEF one cycle after the load request; other RAM words unchanged.
- GPIO:
  - store 0x0000_00A5 to 0x1000_0000 → gpio_out_o = 0xA5 the next cycle;
  - drive gpio_in_i = 0x3C and load 0x1000_0004 two cycles later → rdata_o = 0x3C.
- Counter:
  - after reset, load 0x1000_0008 at cycle 10 → rdata_o = 10;
  - store any value to 0x1000_0008 → subsequent load one cycle later reads 1;
  - force CYCLE = 0xFFFF_FFFF → wraps to 0.
- Timer: store TCMP = 20 → timer_irq_o rises exactly when CYCLE reaches 20 and stays high. Store TCMP = 0 → timer_irq_o = 0 next cycle.
- Bus error:
  - load 0x2000_0000 → rdata_o = 0, bus_err_o = 1 the next cycle and stays high;
  - store to an unmapped address → no RAM or register changes;
  - store 1 to 0x1000_0010 → bus_err_o = 0.
- Reset mid-operation:
  - assert rst asynchronously between clock edges while req_i = 1, we_i = 1 → all outputs 0 immediately and the target is not written;
  - after release, the counter restarts from 0.

Source files
------------

// File: rtl/data_bus_ctrl_pkg.sv
// data_bus_ctrl_pkg
// Shared definitions for the data-side bus controller.
// Contents: the data width, the address map (base address, register
// offsets, STATUS bit positions), the decode-target enum and the address
// decode helper.
package data_bus_ctrl_pkg;

    localparam int DATA_W = 32;

    localparam logic [31:0] RAM_BASE     = 32'h0000_0000;
    localparam logic [31:0] REG_BASE     = 32'h1000_0000;

    localparam logic [31:0] GPIO_OUT_OFF = 32'h0000_0000;
    localparam logic [31:0] GPIO_IN_OFF  = 32'h0000_0004;
    localparam logic [31:0] CYCLE_OFF    = 32'h0000_0008;
    localparam logic [31:0] TCMP_OFF     = 32'h0000_000C;
    localparam logic [31:0] STATUS_OFF   = 32'h0000_0010;

    localparam int STATUS_ERR_BIT = 0;
    localparam int STATUS_IRQ_BIT = 1;

    typedef enum logic [2:0] {
        SEL_RAM,
        SEL_GPIO_OUT,
        SEL_GPIO_IN,
        SEL_CYCLE,
        SEL_TCMP,
        SEL_STATUS,
        SEL_NONE
    } sel_e;

    // The low two address bits are dropped because every access is a
    // full word.
    function automatic sel_e decode_addr(input logic [31:0] addr,
                                         input int unsigned ram_aw);
        logic [31:0] word_addr;
        sel_e        sel;
        word_addr = {addr[31:2], 2'b00};
        sel       = SEL_NONE;
        if (((word_addr - RAM_BASE) >> (ram_aw + 32'd2)) == 32'd0) begin
            sel = SEL_RAM;
        end else begin
            case (word_addr)
                REG_BASE + GPIO_OUT_OFF: sel = SEL_GPIO_OUT;
                REG_BASE + GPIO_IN_OFF:  sel = SEL_GPIO_IN;
                REG_BASE + CYCLE_OFF:    sel = SEL_CYCLE;
                REG_BASE + TCMP_OFF:     sel = SEL_TCMP;
                REG_BASE + STATUS_OFF:   sel = SEL_STATUS;
                default:                 sel = SEL_NONE;
            endcase
        end
        return sel;
    endfunction

endpackage

// File: rtl/data_bus_ctrl_if.sv
// data_bus_ctrl_if
// The core's load/store port as seen by the data bus controller.
//   req_i   : access qualifier, high only in the memory-stage cycle
//   addr_i  : byte address (bits [1:0] ignored)
//   we_i    : 1 = store, 0 = load
//   wdata_i : store data
//   rdata_o : registered load data
// master = core side, slave = controller side.
interface data_bus_ctrl_if;
    import data_bus_ctrl_pkg::*;

    logic              req_i;
    logic [31:0]       addr_i;
    logic              we_i;
    logic [DATA_W-1:0] wdata_i;
    logic [DATA_W-1:0] rdata_o;

    modport master (
        output req_i,
        output addr_i,
        output we_i,
        output wdata_i,
        input  rdata_o
    );

    modport slave (
        input  req_i,
        input  addr_i,
        input  we_i,
        input  wdata_i,
        output rdata_o
    );

endinterface

// File: rtl/data_bus_ctrl_dmem_ram.sv
// dmem_ram
// Single-port synchronous data RAM, 2^AW words of DATA_W bits.
// The write takes effect at the clock edge. The read data is registered
// and only updates when re is high, so it holds between loads. The array
// is not reset.
//   clk   : clock
//   we    : write enable
//   re    : read enable (loads the read register)
//   addr  : word address
//   wdata : write data
//   rdata : registered read data
module dmem_ram
    import data_bus_ctrl_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/data_bus_ctrl.sv
// data_bus_ctrl
// Data-side bus controller for the core's load/store port. It decodes
// each access to the on-chip data RAM or to the register bank:
// GPIO_OUT, GPIO_IN (2-flop synchronised), CYCLE (free-running
// counter), TCMP and STATUS.
//   clk         : system clock, rising edge
//   rst         : asynchronous, active-high reset
//   bus         : load/store port (slave modport)
//   gpio_in_i   : asynchronous external inputs
//   gpio_out_o  : GPIO output register
//   timer_irq_o : CYCLE >= TCMP while TCMP != 0
//   bus_err_o   : sticky unmapped-access flag
module data_bus_ctrl
    import data_bus_ctrl_pkg::*;
#(
    parameter int RAM_AW = 10,
    parameter int GPIO_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    data_bus_ctrl_if.slave    bus,
    input  logic [GPIO_W-1:0] gpio_in_i,
    output logic [GPIO_W-1:0] gpio_out_o,
    output logic              timer_irq_o,
    output logic              bus_err_o
);

    sel_e              sel;
    logic              load;
    logic              store;
    logic              ram_we;
    logic              ram_re;
    logic [DATA_W-1:0] ram_rdata;
    logic [DATA_W-1:0] reg_rdata;

    logic [GPIO_W-1:0] gpio_meta_q;
    logic [GPIO_W-1:0] gpio_sync_q;
    logic [GPIO_W-1:0] gpio_out_q;
    logic [31:0]       cycle_q;
    logic [31:0]       tcmp_q;
    logic              bus_err_q;
    logic              rd_ram_q;
    logic [DATA_W-1:0] reg_rdata_q;

    assign sel   = decode_addr(bus.addr_i, RAM_AW);
    assign load  = bus.req_i & ~bus.we_i;
    assign store = bus.req_i &  bus.we_i;

    // The RAM has no reset. The write is gated here so that an access
    // aborted by reset never reaches the array.
    assign ram_we = store & ~rst & (sel == SEL_RAM);
    assign ram_re = load  & (sel == SEL_RAM);

    dmem_ram #(
        .AW (RAM_AW)
    ) u_dmem_ram (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (bus.addr_i[RAM_AW+1:2]),
        .wdata (bus.wdata_i),
        .rdata (ram_rdata)
    );

    assign timer_irq_o = (tcmp_q != 32'd0) && (cycle_q >= tcmp_q);
    assign bus_err_o   = bus_err_q;
    assign gpio_out_o  = gpio_out_q;

    always_comb begin
        reg_rdata = '0;
        case (sel)
            SEL_GPIO_OUT: reg_rdata = DATA_W'(gpio_out_q);
            SEL_GPIO_IN:  reg_rdata = DATA_W'(gpio_sync_q);
            SEL_CYCLE:    reg_rdata = cycle_q;
            SEL_TCMP:     reg_rdata = tcmp_q;
            SEL_STATUS: begin
                reg_rdata[STATUS_ERR_BIT] = bus_err_q;
                reg_rdata[STATUS_IRQ_BIT] = timer_irq_o;
            end
            default:      reg_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gpio_meta_q <= '0;
            gpio_sync_q <= '0;
            gpio_out_q  <= '0;
            cycle_q     <= '0;
            tcmp_q      <= '0;
            bus_err_q   <= 1'b0;
            rd_ram_q    <= 1'b0;
            reg_rdata_q <= '0;
        end else begin
            gpio_meta_q <= gpio_in_i;
            gpio_sync_q <= gpio_meta_q;

            // A store to CYCLE takes priority over the increment.
            if (store && sel == SEL_CYCLE) begin
                cycle_q <= '0;
            end else begin
                cycle_q <= cycle_q + 32'd1;
            end

            if (store && sel == SEL_GPIO_OUT) begin
                gpio_out_q <= bus.wdata_i[GPIO_W-1:0];
            end
            if (store && sel == SEL_TCMP) begin
                tcmp_q <= bus.wdata_i;
            end

            if (bus.req_i && sel == SEL_NONE) begin
                bus_err_q <= 1'b1;
            end else if (store && sel == SEL_STATUS && bus.wdata_i[STATUS_ERR_BIT]) begin
                bus_err_q <= 1'b0;
            end

            // Only a load moves the read path. rdata_o holds across idle
            // cycles and stores.
            if (load) begin
                rd_ram_q    <= (sel == SEL_RAM);
                reg_rdata_q <= reg_rdata;
            end
        end
    end

    assign bus.rdata_o = rd_ram_q ? ram_rdata : reg_rdata_q;

endmodule

// File: tb/tb_data_bus_ctrl.sv
module tb_data_bus_ctrl;

    localparam int RAM_AW = 10;
    localparam int GPIO_W = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [GPIO_W-1:0] gpio_in = '0;
    logic [GPIO_W-1:0] gpio_out;
    logic              timer_irq;
    logic              bus_err;

    data_bus_ctrl_if bus();

    data_bus_ctrl #(
        .RAM_AW (RAM_AW),
        .GPIO_W (GPIO_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .gpio_in_i   (gpio_in),
        .gpio_out_o  (gpio_out),
        .timer_irq_o (timer_irq),
        .bus_err_o   (bus_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model of the memory map.
    logic [31:0] m_mem [int];
    logic [31:0] m_gpio_out = '0;
    logic [31:0] m_cnt      = '0;
    logic [31:0] m_tcmp     = '0;
    logic [31:0] m_rdata    = '0;
    bit          m_err      = 1'b0;
    bit          m_rd_known = 1'b1;
    logic [31:0] m_gin [$]  = '{32'h0, 32'h0};
    int          force_cnt  = 0;
    int          seen_force = 0;

    function automatic bit m_irq();
        return (m_tcmp != 32'd0) && (m_cnt >= m_tcmp);
    endfunction

    task automatic m_load(input logic [31:0] v);
        m_rdata    = v;
        m_rd_known = 1'b1;
    endtask

    task automatic model_step();
        logic [31:0] a;
        logic [31:0] gin_vis;
        bit          irq0;
        bit          err0;
        bit          clr;
        int          idx;
        if (force_cnt != seen_force) begin
            seen_force = force_cnt;
            m_cnt      = 32'hFFFF_FFFF;
        end
        irq0    = m_irq();
        err0    = m_err;
        gin_vis = m_gin[0];
        clr     = 1'b0;
        if (bus.req_i) begin
            a = {bus.addr_i[31:2], 2'b00};
            if (a < (32'd4 << RAM_AW)) begin
                idx = int'(a >> 2);
                if (bus.we_i) m_mem[idx] = bus.wdata_i;
                else if (m_mem.exists(idx)) m_load(m_mem[idx]);
                else m_rd_known = 1'b0;
            end else begin
                case (a)
                    32'h1000_0000: if (bus.we_i) m_gpio_out = bus.wdata_i; else m_load(m_gpio_out);
                    32'h1000_0004: if (!bus.we_i) m_load(gin_vis);
                    32'h1000_0008: if (bus.we_i) clr = 1'b1; else m_load(m_cnt);
                    32'h1000_000C: if (bus.we_i) m_tcmp = bus.wdata_i; else m_load(m_tcmp);
                    32'h1000_0010: begin
                        if (bus.we_i) begin
                            if (bus.wdata_i[0]) m_err = 1'b0;
                        end else begin
                            m_load({30'b0, irq0, err0});
                        end
                    end
                    default: begin
                        m_err = 1'b1;
                        if (!bus.we_i) m_load(32'h0);
                    end
                endcase
            end
        end
        m_cnt = clr ? 32'h0 : m_cnt + 32'd1;
        void'(m_gin.pop_front());
        m_gin.push_back(gpio_in);
    endtask

    // Model update at each edge, then compare once the DUT has settled.
    always begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_gpio_out = '0;
            m_cnt      = '0;
            m_tcmp     = '0;
            m_rdata    = '0;
            m_err      = 1'b0;
            m_rd_known = 1'b1;
            m_gin      = '{32'h0, 32'h0};
        end else begin
            model_step();
            #1;
            if (m_rd_known) check("cyc_rdata", bus.rdata_o, m_rdata);
            check("cyc_gpio_out", gpio_out, m_gpio_out);
            check("cyc_irq", {31'b0, timer_irq}, {31'b0, m_irq()});
            check("cyc_bus_err", {31'b0, bus_err}, {31'b0, m_err});
        end
    end

    task automatic acc(input bit w, input logic [31:0] a, input logic [31:0] d);
        bus.req_i   = 1'b1;
        bus.we_i    = w;
        bus.addr_i  = a;
        bus.wdata_i = d;
        @(negedge clk);
        bus.req_i   = 1'b0;
        bus.we_i    = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_i   = 1'b0;
        bus.we_i    = 1'b0;
        bus.addr_i  = '0;
        bus.wdata_i = '0;
        repeat (3) @(negedge clk);
        check("rst_rdata", bus.rdata_o, 32'h0);
        check("rst_gpio_out", gpio_out, 32'h0);
        check("rst_irq", {31'b0, timer_irq}, 32'h0);
        check("rst_bus_err", {31'b0, bus_err}, 32'h0);
        rst = 1'b0;

        // Counter reads 10 when loaded in the 11th cycle after reset.
        idle(10);
        acc(1'b0, 32'h1000_0008, 32'h0);
        check("cycle_at_10", bus.rdata_o, 32'd10);

        acc(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
        acc(1'b0, 32'h0000_0010, 32'h0);
        check("ram_load", bus.rdata_o, 32'hDEAD_BEEF);

        acc(1'b1, 32'h1000_0000, 32'h0000_00A5);
        check("gpio_out", gpio_out, 32'h0000_00A5);
        gpio_in = 32'h3C;
        idle(2);
        acc(1'b0, 32'h1000_0004, 32'h0);
        check("gpio_in", bus.rdata_o, 32'h3C);

        acc(1'b1, 32'h1000_0008, 32'h1234);
        acc(1'b0, 32'h1000_0008, 32'h0);
        check("cycle_clear_0", bus.rdata_o, 32'd0);
        acc(1'b1, 32'h1000_0008, 32'h0);
        idle(1);
        acc(1'b0, 32'h1000_0008, 32'h0);
        check("cycle_clear_1", bus.rdata_o, 32'd1);

        // Timer: CYCLE cleared, then TCMP = 20 written one cycle later.
        acc(1'b1, 32'h1000_0008, 32'h0);
        acc(1'b1, 32'h1000_000C, 32'd20);
        idle(18);
        check("timer_at_19", {31'b0, timer_irq}, 32'd0);
        idle(1);
        check("timer_at_20", {31'b0, timer_irq}, 32'd1);
        idle(5);
        check("timer_hold", {31'b0, timer_irq}, 32'd1);
        acc(1'b1, 32'h1000_000C, 32'd0);
        check("timer_off", {31'b0, timer_irq}, 32'd0);

        acc(1'b0, 32'h2000_0000, 32'h0);
        check("unmapped_rdata", bus.rdata_o, 32'h0);
        check("bus_err_set", {31'b0, bus_err}, 32'd1);
        idle(3);
        check("bus_err_sticky", {31'b0, bus_err}, 32'd1);
        acc(1'b1, 32'h2000_0004, 32'hFFFF_FFFF);
        check("unmapped_store_gpio", gpio_out, 32'h0000_00A5);
        acc(1'b0, 32'h0000_0010, 32'h0);
        check("unmapped_store_ram", bus.rdata_o, 32'hDEAD_BEEF);
        acc(1'b1, 32'h1000_0010, 32'h1);
        check("bus_err_clear", {31'b0, bus_err}, 32'd0);

        // Counter wrap.
        force dut.cycle_q = 32'hFFFF_FFFF;
        force_cnt++;
        #1;
        release dut.cycle_q;
        acc(1'b0, 32'h1000_0008, 32'h0);
        check("cycle_max", bus.rdata_o, 32'hFFFF_FFFF);
        acc(1'b0, 32'h1000_0008, 32'h0);
        check("cycle_wrap", bus.rdata_o, 32'd0);

        for (int i = 0; i < 1500; i++) begin
            logic [31:0] a;
            logic [31:0] d;
            bit          w;
            if ($urandom_range(0, 7) == 0) gpio_in = $urandom();
            w = 1'($urandom_range(0, 1));
            d = $urandom();
            case ($urandom_range(0, 11))
                0, 1, 2, 3: a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
                4:  a = ($urandom_range(0, 1) == 1) ? 32'h0000_0FFC : 32'h0000_1000;
                5:  a = 32'h1000_0000;
                6:  a = 32'h1000_0004;
                7: begin
                    a = 32'h1000_0008;
                    if ($urandom_range(0, 3) != 0) w = 1'b0;
                end
                8: begin
                    a = 32'h1000_000C;
                    d = 32'($urandom_range(0, 400));
                end
                9: begin
                    a = 32'h1000_0010;
                    d = 32'($urandom_range(0, 3));
                end
                10: a = 32'h1000_0014 + (32'($urandom_range(0, 15)) << 2);
                default: a = 32'h2000_0000 | ($urandom() & 32'h0FFF_FFFC);
            endcase
            if ($urandom_range(0, 3) == 0) idle(1);
            else acc(w, a, d);
        end

        // Reset in the middle of a store.
        acc(1'b1, 32'h0000_0014, 32'h1111_1111);
        acc(1'b1, 32'h1000_0000, 32'h0000_005A);
        bus.req_i   = 1'b1;
        bus.we_i    = 1'b1;
        bus.addr_i  = 32'h0000_0014;
        bus.wdata_i = 32'h1234_5678;
        #3;
        rst = 1'b1;
        #1;
        check("midrst_rdata", bus.rdata_o, 32'h0);
        check("midrst_gpio_out", gpio_out, 32'h0);
        check("midrst_irq", {31'b0, timer_irq}, 32'h0);
        check("midrst_bus_err", {31'b0, bus_err}, 32'h0);
        @(negedge clk);
        rst       = 1'b0;
        bus.req_i = 1'b0;
        bus.we_i  = 1'b0;
        acc(1'b0, 32'h0000_0014, 32'h0);
        check("midrst_no_write", bus.rdata_o, 32'h1111_1111);
        idle(3);
        acc(1'b0, 32'h1000_0008, 32'h0);
        check("midrst_cycle_restart", bus.rdata_o, 32'd4);

        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
